// File: rtl/addtree_pkg.sv
// Shared sizing helpers for the pipelined signed adder tree.
// Saturating output formatting is enabled with the ADDTREE_SAT_EN macro.
package addtree_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int calc_lvl(input int n_in);
        return clog2(n_in);
    endfunction

    function automatic int calc_full_w(input int in_w, input int n_in);
        return in_w + clog2(n_in);
    endfunction

    function automatic int calc_lat(input int n_in);
        return clog2(n_in) + 1;
    endfunction

    // Number of partial sums present after g tree levels.
    function automatic int lvl_cnt(input int n_in, input int g);
        return (n_in + (1 << g) - 1) >> g;
    endfunction

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/cal_addtree_level.sv
// One registered adder-tree level: M signed W-bit inputs to ceil(M/2) W+1-bit sums.
// Build macro ADDTREE_SAT_EN does not affect this level.
module cal_addtree_level #(
    parameter int M = 2,
    parameter int W = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             in_valid,
    input  logic [M*W-1:0]                   din,
    output logic                             out_valid,
    output logic [((M+1)/2)*(W+1)-1:0]       dout
);

    localparam int MO = (M + 1) / 2;
    localparam int WO = W + 1;

    logic [MO*WO-1:0] nxt;

    always_comb begin
        nxt = '0;
        for (int j = 0; j < M / 2; j++) begin
            nxt[j*WO +: WO] = WO'($signed(din[2*j*W +: W]))
                            + WO'($signed(din[(2*j+1)*W +: W]));
        end
        // An unpaired element rides through, sign-extended.
        if (M % 2 == 1) begin
            nxt[(MO-1)*WO +: WO] = WO'($signed(din[(M-1)*W +: W]));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            dout      <= nxt;
        end
    end

endmodule

// File: rtl/cal_addtree_pipe.sv
// Pipelined signed adder tree with valid/ready back-pressure and output formatting.
// Define ADDTREE_SAT_EN for saturating output; otherwise the sum wraps to OUT_W bits.
module cal_addtree_pipe
    import addtree_pkg::*;
#(
    parameter int N_IN  = 9,
    parameter int IN_W  = 8,
    parameter int OUT_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*IN_W-1:0]   din,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       dout,
    output logic                   sat_flag
);

    localparam int LVL    = calc_lvl(N_IN);
    localparam int FULL_W = calc_full_w(IN_W, N_IN);
    localparam int BW     = N_IN * FULL_W;

    logic             en;
    logic [LVL:0]     vld;
    logic [BW-1:0]    bus [0:LVL];
    logic [FULL_W-1:0] sum;
    logic [OUT_W-1:0] fmt;
    logic             fmt_sat;
    logic             unused_top;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign vld[0] = in_valid;
    assign bus[0] = BW'(din);

    // Each level's bus slot is padded to a common width; only the low bits are live.
    for (genvar g = 0; g < LVL; g++) begin : g_lvl
        localparam int MI = lvl_cnt(N_IN, g);
        localparam int WI = IN_W + g;
        localparam int MO = lvl_cnt(N_IN, g + 1);
        localparam int WO = WI + 1;

        logic [MO*WO-1:0] q;
        logic             unused_pad;

        cal_addtree_level #(
            .M (MI),
            .W (WI)
        ) u_lvl (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (vld[g]),
            .din       (bus[g][MI*WI-1:0]),
            .out_valid (vld[g+1]),
            .dout      (q)
        );

        assign bus[g+1]   = BW'(q);
        assign unused_pad = ^bus[g];
    end

    assign sum        = bus[LVL][FULL_W-1:0];
    assign unused_top = ^bus[LVL];

    if (OUT_W >= FULL_W) begin : g_ext
        assign fmt     = OUT_W'($signed(sum));
        assign fmt_sat = 1'b0;
    end else begin : g_nar
`ifdef ADDTREE_SAT_EN
        localparam logic [OUT_W-1:0] SAT_MAX = OUT_W'(sat_max(OUT_W));
        localparam logic [OUT_W-1:0] SAT_MIN = OUT_W'(sat_min(OUT_W));

        logic [FULL_W-OUT_W:0] hi;
        assign hi = sum[FULL_W-1:OUT_W-1];

        // Fits iff every bit from the OUT_W sign position up agrees.
        always_comb begin
            fmt     = sum[OUT_W-1:0];
            fmt_sat = 1'b0;
            if (!(&hi) && (|hi)) begin
                fmt_sat = 1'b1;
                fmt     = sum[FULL_W-1] ? SAT_MIN : SAT_MAX;
            end
        end
`else
        assign fmt     = sum[OUT_W-1:0];
        assign fmt_sat = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            sat_flag  <= 1'b0;
        end else if (en) begin
            out_valid <= vld[LVL];
            dout      <= fmt;
            sat_flag  <= fmt_sat;
        end
    end

endmodule
